// File: rtl/mac_32.sv
// ============================================================================
// mac_32 : 16x16 unsigned carry-save multiplier with 32-bit accumulate,
//          single registered output stage.
// Rev 1.0
// ============================================================================
`default_nettype none

// 32-bit carry-save (3:2) stage of full adders; carry out of bit 31 drops.
module mac_32_csa (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] sum,
  output logic [31:0] carry
);
  assign sum   = a ^ b ^ c;
  assign carry = {(a[30:0] & b[30:0]) | (a[30:0] & c[30:0]) | (b[30:0] & c[30:0]), 1'b0};
endmodule

module mac_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] reg1,
  input  logic [15:0] reg2,
  input  logic [31:0] add1,
  output logic [31:0] mul_out,
  output logic [31:0] mac_out,
  output logic        out_valid
);
  logic [31:0] w_l0 [16];
  logic [31:0] w_l1 [11];
  logic [31:0] w_l2 [8];
  logic [31:0] w_l3 [6];
  logic [31:0] w_l4 [4];
  logic [31:0] w_l5 [3];
  logic [31:0] w_l6 [2];
  logic [31:0] w_mac_s, w_mac_c;
  logic [31:0] w_mul, w_mac;
  logic [31:0] r_mul, r_mac;
  logic        r_valid;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_pp
      assign w_l0[i] = {16'd0, reg1 & {16{reg2[i]}}} << i;
    end

    // Wallace-style reduction: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
    for (genvar k = 0; k < 5; k++) begin : g_l1
      mac_32_csa u_csa (.a(w_l0[3*k]), .b(w_l0[3*k+1]), .c(w_l0[3*k+2]),
                        .sum(w_l1[2*k]), .carry(w_l1[2*k+1]));
    end
    assign w_l1[10] = w_l0[15];

    for (genvar k = 0; k < 3; k++) begin : g_l2
      mac_32_csa u_csa (.a(w_l1[3*k]), .b(w_l1[3*k+1]), .c(w_l1[3*k+2]),
                        .sum(w_l2[2*k]), .carry(w_l2[2*k+1]));
    end
    assign w_l2[6] = w_l1[9];
    assign w_l2[7] = w_l1[10];

    for (genvar k = 0; k < 2; k++) begin : g_l3
      mac_32_csa u_csa (.a(w_l2[3*k]), .b(w_l2[3*k+1]), .c(w_l2[3*k+2]),
                        .sum(w_l3[2*k]), .carry(w_l3[2*k+1]));
    end
    assign w_l3[4] = w_l2[6];
    assign w_l3[5] = w_l2[7];

    for (genvar k = 0; k < 2; k++) begin : g_l4
      mac_32_csa u_csa (.a(w_l3[3*k]), .b(w_l3[3*k+1]), .c(w_l3[3*k+2]),
                        .sum(w_l4[2*k]), .carry(w_l4[2*k+1]));
    end
  endgenerate

  mac_32_csa u_csa_l5 (.a(w_l4[0]), .b(w_l4[1]), .c(w_l4[2]),
                       .sum(w_l5[0]), .carry(w_l5[1]));
  assign w_l5[2] = w_l4[3];

  mac_32_csa u_csa_l6 (.a(w_l5[0]), .b(w_l5[1]), .c(w_l5[2]),
                       .sum(w_l6[0]), .carry(w_l6[1]));

  // Addend merged as one more carry-save stage ahead of its own final adder.
  mac_32_csa u_csa_acc (.a(w_l6[0]), .b(w_l6[1]), .c(add1),
                        .sum(w_mac_s), .carry(w_mac_c));

  assign w_mul = w_l6[0] + w_l6[1];
  assign w_mac = w_mac_s + w_mac_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul   <= '0;
      r_mac   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_mul <= w_mul;
        r_mac <= w_mac;
      end
    end
  end

  assign mul_out   = r_mul;
  assign mac_out   = r_mac;
  assign out_valid = r_valid;
endmodule

`default_nettype wire

// File: tb/tb_mac_32.sv
// ============================================================================
// tb_mac_32 : directed and random self-checking bench for mac_32.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] reg1, reg2;
  logic [31:0] add1;
  logic [31:0] mul_out, mac_out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  mac_32 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .reg1(reg1), .reg2(reg2), .add1(add1),
    .mul_out(mul_out), .mac_out(mac_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] m, input logic [31:0] a,
                      input logic v);
    chk({tag, ".mul"}, mul_out, m);
    chk({tag, ".mac"}, mac_out, a);
    chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  // Apply operands at the falling edge, observe 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] c);
    @(negedge clk);
    in_valid = v; reg1 = a; reg2 = b; add1 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] rc, em, ea;

    rst_n = 1'b0; in_valid = 1'b0; reg1 = '0; reg2 = '0; add1 = '0;
    #1;
    chk3("reset", 32'd0, 32'd0, 1'b0);
    step(1'b1, 16'd9, 16'd9, 32'd9);
    chk3("reset_ignores_inputs", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 16'd3, 16'd5, 32'd100);
    chk3("basic", 32'd15, 32'd115, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 32'h0001FFFF);
    chk3("wrap", 32'hFFFE0001, 32'h00000000, 1'b1);
    step(1'b1, 16'd0, 16'hABCD, 32'hDEADBEEF);
    chk3("zero_reg1", 32'd0, 32'hDEADBEEF, 1'b1);
    step(1'b1, 16'h1234, 16'd0, 32'h00C0FFEE);
    chk3("zero_reg2", 32'd0, 32'h00C0FFEE, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 32'd0);
    chk3("max_product", 32'hFFFE0001, 32'hFFFE0001, 1'b1);
    step(1'b1, 16'h8000, 16'h8000, 32'hC0000000);
    chk3("msb_only", 32'h40000000, 32'h00000000, 1'b1);
    step(1'b1, 16'd2, 16'd7, 32'd1);
    chk3("hold_load", 32'd14, 32'd15, 1'b1);
    step(1'b0, 16'd11, 16'd13, 32'd1000);
    chk3("hold_1", 32'd14, 32'd15, 1'b0);
    step(1'b0, 16'hFFFF, 16'h00FF, 32'hFFFFFFFF);
    chk3("hold_2", 32'd14, 32'd15, 1'b0);
    step(1'b1, 16'd1000, 16'd1000, 32'd5);
    chk3("resume", 32'd1000000, 32'd1000005, 1'b1);

    // Reset pulsed between edges while operands are valid.
    @(negedge clk);
    in_valid = 1'b1; reg1 = 16'd77; reg2 = 16'd77; add1 = 32'd1;
    #1 rst_n = 1'b0;
    #1;
    chk3("async_reset", 32'd0, 32'd0, 1'b0);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk3("no_stale_after_reset", 32'd0, 32'd0, 1'b0);
    step(1'b1, 16'd6, 16'd7, 32'd8);
    chk3("first_after_reset", 32'd42, 32'd50, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = $urandom;
      em = {16'd0, ra} * {16'd0, rb};
      ea = em + rc;
      step(1'b1, ra, rb, rc);
      chk3("random", em, ea, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
